// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Ports:
//   clk_i, rst_i (async, active-low)
//   cpu_enable_i, cpu_write_i, cpu_addr_i, cpu_data_i -> cpu_data_o, cpu_stall_o
//   mem_enable_o, mem_write_o, mem_addr_o, mem_data_o <- mem_data_i, mem_ack_i (line-wide memory port)
module dcache_controller #(
   parameter int NUM_SETS  = 16,
   parameter int LINE_BITS = 256,
   parameter int TAG_W     = 32 - 5 - $clog2(NUM_SETS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_enable_i,
   input  logic                 cpu_write_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);
   localparam int IDX_W = $clog2(NUM_SETS);
   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
   state_t state;
   logic [LINE_BITS-1:0] lines [NUM_SETS];
   logic [TAG_W-1:0] tags [NUM_SETS];
   logic [NUM_SETS-1:0] valid, dirty;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [2:0] word;
   logic hit, store_hit, fill, unused_bits;
   assign idx = cpu_addr_i[IDX_W+4:5];
   assign tag = cpu_addr_i[31:IDX_W+5];
   assign word = cpu_addr_i[4:2];
   assign unused_bits = ^cpu_addr_i[1:0];
   assign hit = state == IDLE && valid[idx] && tags[idx] == tag;
   assign store_hit = cpu_enable_i && cpu_write_i && hit;
   assign fill = state == ALLOCATE && mem_ack_i;
   // gated by reset so the pipeline is released the moment reset is asserted
   assign cpu_stall_o = rst_i && cpu_enable_i && !hit;
   assign cpu_data_o = hit && !cpu_write_i ? lines[idx][{word, 5'b0} +: 32] : '0;
   // data/tag arrays carry no reset; valid bits guard them
   always_ff @(posedge clk_i) begin
      if (fill) begin
         lines[idx] <= mem_data_i;
         tags[idx] <= tag;
      end else if (store_hit) begin
         lines[idx][{word, 5'b0} +: 32] <= cpu_data_i;
      end
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (store_hit) dirty[idx] <= 1'b1;
               if (cpu_enable_i && !hit) begin
                  mem_enable_o <= 1'b1;
                  // victim address comes from the stored tag, not the request
                  if (valid[idx] && dirty[idx]) begin
                     state <= WRITEBACK;
                     mem_write_o <= 1'b1;
                     mem_addr_o <= {tags[idx], idx, 5'b0};
                     mem_data_o <= lines[idx];
                  end else begin
                     state <= ALLOCATE;
                     mem_write_o <= 1'b0;
                     mem_addr_o <= {tag, idx, 5'b0};
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  state <= ALLOCATE;
                  mem_write_o <= 1'b0;
                  mem_addr_o <= {tag, idx, 5'b0};
                  mem_data_o <= '0;
               end
            end
            ALLOCATE: begin
               // completes even if the request was flushed meanwhile
               if (mem_ack_i) begin
                  state <= IDLE;
                  mem_enable_o <= 1'b0;
                  mem_addr_o <= '0;
                  valid[idx] <= 1'b1;
                  dirty[idx] <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
